// File: rtl/phase_sequencer.sv
// phase_sequencer
//   Sequences the multi-cycle SIMPLE datapath. It drives a one-hot phase enable
//   for every phase-clocked register stage and adds run/stop control, single
//   stepping, halting at instruction boundaries and a count of retired
//   instructions.
//
//   Optional feature macro: PHASE_SKIP_EN. When it is defined, early_done ends
//   an instruction in the current phase. When it is undefined, early_done is
//   ignored.
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   exec_pulse   one-cycle pulse from the debounced exec button
//   step_mode    1 = execute one instruction per exec_pulse
//   halt         halt request, sampled only in the final phase
//   early_done   current phase is the last one this instruction needs
//   p            one-hot phase enable, zero when not running
//   phase_idx    binary index of the active phase, zero when not running
//   instr_done   high during the final phase cycle of an instruction
//   running      sequencer is in RUN
//   halted       sequencer is in HALTED
//   instr_count  completed instructions, wraps modulo 2**CNT_W
module phase_sequencer #(
  parameter int NUM_PHASES = 5,
  parameter int PH_W       = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  exec_pulse,
  input  logic                  step_mode,
  input  logic                  halt,
  input  logic                  early_done,
  output logic [NUM_PHASES-1:0] p,
  output logic [PH_W-1:0]       phase_idx,
  output logic                  instr_done,
  output logic                  running,
  output logic                  halted,
  output logic [CNT_W-1:0]      instr_count
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_e;

  localparam logic [PH_W-1:0] LAST_PH = PH_W'(NUM_PHASES - 1);

  state_e                state_q, state_d;
  logic                  stop_q, stop_d;
  logic [PH_W-1:0]       phase_q, phase_d;
  logic [NUM_PHASES-1:0] p_q, p_d;
  logic                  running_q, running_d;
  logic                  halted_q, halted_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  last_ph;
  logic                  final_c;

`ifdef PHASE_SKIP_EN
  // An early finish simply makes the current phase the final one.
  assign last_ph = (phase_q == LAST_PH) || early_done;
`else
  logic unused_early_done;
  assign unused_early_done = early_done;
  assign last_ph = (phase_q == LAST_PH);
`endif

  assign final_c = (state_q == S_RUN) && last_ph;

  // State register and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      stop_q    <= 1'b0;
      phase_q   <= '0;
      p_q       <= '0;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      stop_q    <= stop_d;
      phase_q   <= phase_d;
      p_q       <= p_d;
      running_q <= running_d;
      halted_q  <= halted_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state logic. A stop request made in the final phase of an
  // instruction applies to the following boundary. When the current boundary
  // already returns to IDLE, the request is dropped.
  always_comb begin
    state_d = state_q;
    stop_d  = stop_q;
    unique case (state_q)
      S_IDLE: begin
        stop_d = 1'b0;
        if (exec_pulse) state_d = S_RUN;
      end
      S_RUN: begin
        if (final_c) begin
          if (halt) begin
            state_d = S_HALTED;
            stop_d  = 1'b0;
          end else if (step_mode || stop_q) begin
            state_d = S_IDLE;
            stop_d  = 1'b0;
          end else begin
            stop_d  = exec_pulse;
          end
        end else if (exec_pulse && !step_mode) begin
          stop_d = 1'b1;
        end
      end
      S_HALTED: begin
        stop_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        stop_d  = 1'b0;
      end
    endcase
  end

  // Next values of the registered outputs, derived from the next state.
  // A new instruction starts at phase 0 on the edge that leaves IDLE and on
  // every boundary that stays in RUN, so there is no bubble cycle.
  always_comb begin
    phase_d   = '0;
    p_d       = '0;
    running_d = (state_d == S_RUN);
    halted_d  = (state_d == S_HALTED);
    cnt_d     = final_c ? cnt_q + CNT_W'(1) : cnt_q;
    if (state_d == S_RUN) begin
      phase_d = (state_q == S_RUN && !final_c) ? phase_q + PH_W'(1) : '0;
      p_d     = NUM_PHASES'(1) << phase_d;
    end
  end

  assign p           = p_q;
  assign phase_idx   = phase_q;
  assign instr_done  = final_c;
  assign running     = running_q;
  assign halted      = halted_q;
  assign instr_count = cnt_q;

endmodule
